// File: rtl/tile_pkg.sv
// Shared types and default geometry for the tile write path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tile_pkg;

  localparam int ADDR_BITS     = 12;
  localparam int DEF_TILE_W    = 24;
  localparam int DEF_TILE_H    = 24;
  localparam int DEF_WORD_BITS = 256;
  localparam int DEF_PIX_BITS  = 8;

  // ACCUM gathers one column of pixels, WRITE emits it as a single BRAM word.
  typedef enum logic {
    ACCUM = 1'b0,
    WRITE = 1'b1
  } state_t;

endpackage

// File: rtl/tile_writer_if.sv
// Pixel-in handshake plus BRAM write port of the tile writer.
// Latency: n/a (wires only).
// Backpressure: pixel_ready is driven by the writer; the BRAM side has none.
interface tile_writer_if
  import tile_pkg::*;
#(
  parameter int PIX_BITS  = DEF_PIX_BITS,
  parameter int WORD_BITS = DEF_WORD_BITS
) ();

  logic [PIX_BITS-1:0]  pixel_in;
  logic                 pixel_valid;
  logic                 pixel_ready;
  logic [ADDR_BITS-1:0] bram_addr;
  logic [WORD_BITS-1:0] bram_wdata;
  logic                 bram_we;
  logic                 tile_done;

  // Pixel producer / BRAM sink side.
  modport master (
    output pixel_in, pixel_valid,
    input  pixel_ready, bram_addr, bram_wdata, bram_we, tile_done
  );

  // Tile writer side.
  modport slave (
    input  pixel_in, pixel_valid,
    output pixel_ready, bram_addr, bram_wdata, bram_we, tile_done
  );

endinterface

// File: rtl/tile_writer.sv
// Packs a column-major pixel stream into one BRAM word per tile column.
// Latency: column word written the cycle after its TILE_H-th pixel is accepted.
// Backpressure: pixel_ready drops for exactly the one WRITE cycle per column.
module tile_writer
  import tile_pkg::*;
#(
  parameter logic [ADDR_BITS-1:0] BASE_ADDR = '0,
  parameter int TILE_W    = DEF_TILE_W,
  parameter int TILE_H    = DEF_TILE_H,
  parameter int WORD_BITS = DEF_WORD_BITS,
  // TILE_H*PIX_BITS must not exceed WORD_BITS.
  parameter int PIX_BITS  = DEF_PIX_BITS
) (
  input logic          clk,
  input logic          rst_n,
  input logic          clear,
  tile_writer_if.slave bus
);

  localparam int COL_BITS = TILE_H * PIX_BITS;
  localparam int RW       = (TILE_H > 1) ? $clog2(TILE_H) : 1;
  localparam int CW       = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(TILE_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(TILE_W - 1);

  state_t              state_q, state_d;
  logic [RW-1:0]       row_q, row_d;
  logic [CW-1:0]       col_q, col_d;
  logic [COL_BITS-1:0] buf_q, buf_d;

  // State register; reset drops any partial column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      row_q   <= '0;
      col_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      buf_q   <= buf_d;
    end
  end

  // Next state: clear beats everything, including advancing col after a write.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    buf_d   = buf_q;
    if (clear) begin
      state_d = ACCUM;
      row_d   = '0;
      col_d   = '0;
      buf_d   = '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (bus.pixel_valid) begin
            buf_d[row_q*PIX_BITS +: PIX_BITS] = bus.pixel_in;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = WRITE;
            end else begin
              row_d = row_q + 1'b1;
            end
          end
        end
        WRITE: begin
          col_d   = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
          buf_d   = '0;
          state_d = ACCUM;
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  // Outputs decode purely from state; word is zero outside WRITE and above the column.
  always_comb begin
    bus.pixel_ready = (state_q == ACCUM);
    bus.bram_we     = (state_q == WRITE);
    bus.tile_done   = (state_q == WRITE) && (col_q == COL_LAST);
    bus.bram_addr   = BASE_ADDR + ADDR_BITS'(col_q);
    bus.bram_wdata  = '0;
    if (state_q == WRITE) begin
      bus.bram_wdata[COL_BITS-1:0] = buf_q;
    end
  end

endmodule

// File: doc/tile_writer.md
TILE_WRITER -- requirements
Module: tile_writer

Interface
REQ-001 Parameter BASE_ADDR, default 12'h000, BRAM word address of tile column 0.
REQ-002 Parameter TILE_W, default 24, columns per tile.
REQ-003 Parameter TILE_H, default 24, pixels (rows) per column word.
REQ-004 Parameter WORD_BITS, default 256, BRAM word width.
REQ-005 Parameter PIX_BITS, default 8, pixel width; TILE_H*PIX_BITS <= WORD_BITS.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 clear  input  1  synchronous abort; returns block to empty-tile state.
REQ-009 pixel_in  input  PIX_BITS  incoming pixel, column-major order.
REQ-010 pixel_valid  input  1  pixel_in valid.
REQ-011 pixel_ready  output  1  block accepts pixel this cycle.
REQ-012 bram_addr  output  12  write address = BASE_ADDR + col_idx.
REQ-013 bram_wdata  output  WORD_BITS  packed column word.
REQ-014 bram_we  output  1  BRAM write strobe, one cycle per column.
REQ-015 tile_done  output  1  one-cycle pulse, last column of tile written.

Function
REQ-016 States: ACCUM, WRITE; reset state ACCUM.
REQ-017 Handshake: pixel accepted on cycle where pixel_valid && pixel_ready; pixel_ready = (state == ACCUM), independent of pixel_valid.
REQ-018 Accepted pixel stored in col_buf[row_idx*PIX_BITS +: PIX_BITS]; row_idx increments per accept.
REQ-019 Accept at row_idx == TILE_H-1: row_idx -> 0, state -> WRITE next cycle.
REQ-020 WRITE lasts exactly one cycle: bram_we = 1, bram_wdata = col_buf, bram_addr = BASE_ADDR + col_idx; pixel_ready = 0.
REQ-021 Leaving WRITE: col_idx -> col_idx+1, wrapping TILE_W-1 -> 0; col_buf cleared to 0; state -> ACCUM.
REQ-022 tile_done = 1 only during WRITE with col_idx == TILE_W-1.
REQ-023 Bits of bram_wdata above TILE_H*PIX_BITS are always 0.
REQ-024 Throughput: one column per TILE_H+1 cycles under continuous valid; no pixel dropped or duplicated.
REQ-025 bram_we = 0 and tile_done = 0 in ACCUM.
REQ-026 pixel_valid low in ACCUM: no state change; partial column retained indefinitely.
REQ-027 clear = 1: next cycle state ACCUM, row_idx = 0, col_idx = 0, col_buf = 0; any pixel presented that cycle discarded; clear takes priority over WRITE (a write in progress completes its single strobe cycle but col_idx does not advance).
REQ-028 Packing layout matches the column-major word format consumed by the tile reading path: row r at bits [r*PIX_BITS +: PIX_BITS].

Reset
REQ-029 rst_n low asynchronously forces: state ACCUM, row_idx 0, col_idx 0, col_buf 0.
REQ-030 During and after reset: pixel_ready 1, bram_we 0, tile_done 0, bram_addr BASE_ADDR, bram_wdata 0.
REQ-031 Reset mid-column or mid-WRITE discards partial data; no BRAM write is issued on the reset-deassert cycle.

Structure
REQ-032 Shared package tile_pkg holds state typedef (ACCUM, WRITE) and default tile constants (24, 24, 256, 8).
REQ-033 Single module, no sub-modules; row_idx and col_idx sized $clog2 of TILE_H and TILE_W.

Verification
REQ-034 Continuous stream, pixels 0..23 -> one bram_we at cycle 25, addr 12'h000, wdata[191:0] = bytes 0x17..0x00 (row 0 in LSB), wdata[255:192] = 0.
REQ-035 Full tile 576 pixels, value = col*24+row mod 256 -> 24 writes, addrs 0..23, tile_done once with addr 23, next column writes addr 0.
REQ-036 Random valid gaps (50%) over one tile -> identical write data/addresses to REQ-035; pixel_ready low only on WRITE cycles.
REQ-037 clear after 10 pixels of column 3 -> no write, next 24 pixels written to addr BASE_ADDR.
REQ-038 rst_n asserted asynchronously mid-column 5 -> outputs at reset values immediately, next full column written to BASE_ADDR.
REQ-039 BASE_ADDR = 12'h100 -> writes at 12'h100..12'h117, wrap back to 12'h100.
